// File: rtl/cpu_pkg.sv
// Shared types for the multiply/divide sequencer: op codes, iteration count,
// FSM states and the operand-magnitude helper used at latch time.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step: shift-add multiply (multiplier held in acc[31:0]) or
// restoring shift-subtract divide (partial remainder in acc[32:0]).
module muldiv_iter_core (
    input  logic        is_div,
    input  logic [63:0] acc_i,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    output logic [63:0] acc_o,
    output logic [31:0] x_o
);
    logic [32:0] add_sum;
    logic [32:0] rem_sh;
    logic [33:0] trial;

    always_comb begin
        add_sum = {1'b0, acc_i[63:32]} + {1'b0, (acc_i[0] ? y_i : 32'd0)};
        rem_sh  = {acc_i[31:0], x_i[31]};
        trial   = {1'b0, rem_sh} - {2'b00, y_i};
        acc_o   = acc_i;
        x_o     = x_i;
        if (is_div) begin
            // a clear borrow bit means the divisor fits: keep the difference, quotient bit 1
            if (!trial[33]) begin
                acc_o = {31'd0, trial[32:0]};
                x_o   = {x_i[30:0], 1'b1};
            end else begin
                acc_o = {31'd0, rem_sh};
                x_o   = {x_i[30:0], 1'b0};
            end
        end else begin
            acc_o = {add_sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// MIPS HI/LO owner: sequences MULT/MULTU/DIV/DIVU over the iteration core and
// executes MTHI/MTLO directly.
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO complete here
//   RUN   | one iteration per cycle, ITER cycles
//   FIX   | sign fix-up and HI/LO write
//   DONE  | one-cycle done pulse
module muldiv_hilo_ctrl
    import cpu_pkg::*;
#(
    parameter int          ITER    = MULDIV_ITER,
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    muldiv_state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   acc_q, acc_d;
    logic [31:0]   x_q, x_d, y_q, y_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          is_div_q, is_div_d, div0_q, div0_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d;
    logic [63:0]   core_acc;
    logic [31:0]   core_x;
    muldiv_op_t    op_e;
    logic          sgn;

    assign op_e = muldiv_op_t'(op);

    muldiv_iter_core u_core (
        .is_div (is_div_q),
        .acc_i  (acc_q),
        .x_i    (x_q),
        .y_i    (y_q),
        .acc_o  (core_acc),
        .x_o    (core_x)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        sgn      = (op_e == OP_MULT) || (op_e == OP_DIV);
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    case (op_e)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            neg_p_d  = sgn & (a[31] ^ b[31]);
                            neg_r_d  = sgn & a[31];
                            is_div_d = op[1];
                            count_d  = '0;
                            div0_d   = 1'b0;
                            acc_d    = '0;
                            state_d  = ST_RUN;
                            if (!op[1]) begin
                                acc_d = {32'd0, mag32(b, sgn)};
                                y_d   = mag32(a, sgn);
                            end else if (b == 32'd0) begin
                                // divide by zero skips iteration; raw a is kept for HI
                                div0_d  = 1'b1;
                                x_d     = a;
                                state_d = ST_FIX;
                            end else begin
                                x_d = mag32(a, sgn);
                                y_d = mag32(b, sgn);
                            end
                        end
                        OP_MTHI: begin
                            hi_d    = a;
                            state_d = ST_DONE;
                        end
                        OP_MTLO: begin
                            lo_d    = a;
                            state_d = ST_DONE;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = core_acc;
                    x_d   = core_x;
                    if (count_q == LAST) state_d = ST_FIX;
                    else                 count_d = count_q + 1'b1;
                end
            end
            ST_FIX: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    if (div0_q) begin
                        lo_d = DIV0_LO;
                        hi_d = x_q;
                    end else if (is_div_q) begin
                        lo_d = neg_p_q ? (~x_q + 32'd1) : x_q;
                        hi_d = neg_r_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                    end else begin
                        {hi_d, lo_d} = neg_p_q ? (~acc_q + 64'd1) : acc_q;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed and random checks of muldiv_hilo_ctrl against an arithmetic HI/LO model.
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        abort;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    muldiv_hilo_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one op, from plain signed/unsigned arithmetic.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (o)
            3'd0: begin p = 64'(sa * sb); model_hi = p[63:32]; model_lo = p[31:0]; end
            3'd1: begin p = {32'd0, av} * {32'd0, bv}; model_hi = p[63:32]; model_lo = p[31:0]; end
            3'd2, 3'd3: begin
                if (bv == 32'd0) begin
                    model_lo = 32'hFFFF_FFFF;
                    model_hi = av;
                end else if (o == 3'd2) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    model_lo = sq[31:0];
                    model_hi = sr[31:0];
                end else begin
                    model_lo = av / bv;
                    model_hi = av % bv;
                end
            end
            3'd4: model_hi = av;
            3'd5: model_lo = av;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input string tag);
        int lat_exp, lat, busy_err;
        lat_exp = (o >= 3'd4) ? 1 : ((o >= 3'd2 && bv == 32'd0) ? 2 : 34);
        model_apply(o, av, bv);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        busy_err = 0;
        while (!done && lat < 60) begin
            if (busy !== 1'b1) busy_err++;
            if (lat == 5) begin
                start = 1'b1;
                op = 3'($urandom_range(0, 7));
            end
            tick();
            start = 1'b0;
            lat++;
        end
        if (busy !== 1'b0) busy_err++;
        chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
        chk({tag, " busy"}, 64'(busy_err), 64'd0);
        chk({tag, " hi"}, 64'(hi), 64'(model_hi));
        chk({tag, " lo"}, 64'(lo), 64'(model_lo));
        tick();
        chk({tag, " done width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dn;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; abort = 1'b0;
        #12;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op(3'd0, 32'hFFFF_FFFB, 32'd2, "mult neg");
        run_op(3'd1, 32'hFFFF_FFFB, 32'd2, "multu");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div neg");
        run_op(3'd3, 32'd5, 32'd2, "divu");
        run_op(3'd3, 32'd5, 32'd0, "divu by zero");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        run_op(3'd4, 32'h1234_5678, 32'd0, "mthi");
        run_op(3'd5, 32'hCAFE_F00D, 32'd0, "mtlo");
        run_op(3'd2, 32'hFFFF_FFF0, 32'd0, "div neg by zero");

        // reserved op: nothing happens
        op = 3'd6; a = 32'hDEAD_BEEF; start = 1'b1;
        tick();
        start = 1'b0;
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            if (done || busy) dn++;
            tick();
        end
        chk("reserved op activity", 64'(dn), 64'd0);
        chk("reserved op hi", 64'(hi), 64'(model_hi));

        // abort together with start in IDLE: abort wins
        op = 3'd4; a = 32'h0BAD_0BAD; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort+start done", 64'(done), 64'd0);
        chk("abort+start hi", 64'(hi), 64'(model_hi));

        // abort mid-RUN, with an ignored start while busy
        op = 3'd0; a = $urandom; b = $urandom; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin start = 1'b1; op = 3'd5; a = 32'h5555_AAAA; end
            tick();
            start = 1'b0;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort run busy", 64'(busy), 64'd0);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dn++;
            tick();
        end
        chk("abort run no done", 64'(dn), 64'd0);
        chk("abort run hi", 64'(hi), 64'(model_hi));
        chk("abort run lo", 64'(lo), 64'(model_lo));

        // abort in FIX (divide by zero reaches FIX in cycle 1)
        op = 3'd3; a = 32'd77; b = 32'd0; start = 1'b1;
        tick();
        start = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) dn++;
            tick();
        end
        chk("abort fix no done", 64'(dn), 64'd0);
        chk("abort fix lo", 64'(lo), 64'(model_lo));

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 5));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, $sformatf("rand%0d op%0d", i, ro));
        end

        // asynchronous reset mid-RUN
        op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        #2 rst_n = 1'b0;
        #1;
        model_hi = 32'd0;
        model_lo = 32'd0;
        chk("midrun reset hi", 64'(hi), 64'd0);
        chk("midrun reset lo", 64'(lo), 64'd0);
        chk("midrun reset busy", 64'(busy), 64'd0);
        #3 rst_n = 1'b1;
        tick();
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "after reset mult");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
Multi-cycle sequencer for the MIPS multiply/divide path. It owns the architectural HI/LO registers and executes MULT, MULTU, DIV and DIVU with an iterative radix-2 engine. It also executes MTHI and MTLO. It sits beside the main ALU in EX: the decoder issues a start pulse, and the pipeline stalls on busy for any MFHI/MFLO or new mul/div op.

Parameters:
ITER, 32, number of iteration cycles; equals the operand width and is fixed at 32 for this CPU.
DIV0_LO, 32'hFFFF_FFFF, LO value written on divide by zero.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only while busy=0
op  in  3  muldiv_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 reserved
a  in  32  rs operand (dividend or multiplicand; source for MTHI/MTLO)
b  in  32  rt operand (divisor or multiplier)
abort  in  1  exception flush; kills an in-flight op
busy  out  1  high while an op is in flight
done  out  1  one-cycle pulse; hi/lo hold the new result in that cycle
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0, internal accumulators=0. Reset mid-operation discards the op.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, start=1, op in {MULT,MULTU,DIV,DIVU}:
  - latch magnitudes of a and b (absolute value for signed ops, raw value for unsigned ops);
  - latch the result sign flags: quotient/product sign = sign(a) XOR sign(b); remainder sign = sign(a);
  - count=0; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op=MTHI or MTLO: hi (resp. lo) <= a at that edge; go to DONE; busy stays 0.
- IDLE, start=1, reserved op: ignored; stays IDLE; no done.
- RUN, multiply: shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring shift-subtract, one quotient bit per cycle.
- RUN exit: after ITER cycles (count==ITER-1), go to FIX.
- FIX (one cycle):
  - apply two's-complement negation where the sign flags require it;
  - write {hi,lo}=64-bit product, or lo=quotient, hi=remainder;
  - go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; return to IDLE. A start in DONE is ignored; the issuer waits for IDLE.
- Latency, mul/div: start at edge 0; RUN on cycles 1..32; FIX on cycle 33; done=1 and new hi/lo visible in cycle 34. busy=1 on cycles 1..33.
- Latency, MTHI/MTLO: hi/lo updated at edge 0; done=1 in cycle 1.
- Divide by zero (b==0, DIV or DIVU): no iteration; go straight to FIX; lo=DIV0_LO, hi=a; done follows in the next cycle.
- Signed overflow (0x8000_0000 / -1): the magnitude algorithm naturally gives lo=0x8000_0000, hi=0. No trap.
- start while busy=1: ignored. The request is neither queued nor able to corrupt the in-flight op.
- abort=1 in RUN or FIX: return to IDLE next cycle; hi/lo unchanged; no done pulse.
- abort=1 with start=1 in IDLE: abort wins; nothing is launched.
- Width rules: all internal arithmetic is unsigned 64-bit (multiply) or 33-bit partial remainder (divide). Sign handling is done only at latch time and in FIX.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic [2:0] muldiv_op_t;
  - localparam MULDIV_ITER=32;
  - the FSM state enum.
- One natural sub-module, muldiv_iter_core: the datapath for a single iteration step (shift-add or shift-subtract), selected by an is_div input. The controller owns the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFB, b=2 -> done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFF6; busy high cycles 1..33.
- MULTU a=0xFFFFFFFB, b=2 -> hi=0x00000001, lo=0xFFFFFFF6.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=5, b=2 -> lo=2, hi=1.
- DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, with done 2 cycles after start. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 -> hi=0x12345678 visible at the edge after start; done pulse in cycle 1; lo unchanged.
- MULT started, abort in cycle 10 -> IDLE next cycle; hi/lo keep their prior values; no done. A start issued in cycle 5 (while busy) is ignored. rst_n low mid-RUN -> hi=lo=0 immediately.
